// File: rtl/uart_pkg.sv
// Shared types and parameter checks for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  // True when the configuration can be built.
  function automatic bit params_ok(input int clock_rate, input int baud_rate,
                                   input int n_bits, input int n_samples,
                                   input int parity, input int stop_bits);
    bit ok;
    ok = 1'b1;
    if (baud_rate <= 0 || n_samples <= 0) ok = 1'b0;
    else if (clock_rate / (baud_rate * n_samples) < 2) ok = 1'b0;
    if (n_bits < 5 || n_bits > 9) ok = 1'b0;
    if (n_samples != 4 && n_samples != 8 && n_samples != 16) ok = 1'b0;
    if (parity < 0 || parity > 2) ok = 1'b0;
    if (stop_bits < 1 || stop_bits > 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: synchroniser, start-edge detect, oversampling tick and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DIVISOR   = 25,
  parameter int N_SAMPLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_s,
  output logic fall_edge,
  output logic bit_valid,
  output logic bit_value
);

  localparam int TW = $clog2(DIVISOR);
  localparam int SW = $clog2(N_SAMPLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIVISOR - 1);
  localparam logic [SW-1:0] IDX_LAST  = SW'(N_SAMPLES - 1);
  localparam logic [SW-1:0] IDX_V0    = SW'(N_SAMPLES / 2 - 1);
  localparam logic [SW-1:0] IDX_V1    = SW'(N_SAMPLES / 2);
  localparam logic [SW-1:0] IDX_V2    = SW'(N_SAMPLES / 2 + 1);

  logic [1:0]    sync;
  logic [1:0]    fill;
  logic          rx_prev;
  logic          armed;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] samp_idx;
  logic          tick;
  logic          v0, v1;

  // Two-flop synchroniser for the asynchronous line, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx};
  end

  // Edge history; edges are armed only once a genuine high has been seen
  // after reset, so a line held low across reset is not taken as a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill    <= 2'b00;
      rx_prev <= 1'b1;
      armed   <= 1'b0;
    end else begin
      fill    <= {fill[0], 1'b1};
      rx_prev <= rx_s;
      armed   <= armed | (fill[1] & rx_s);
    end
  end

  // Tick divider and sample index, both realigned to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      samp_idx <= '0;
    end else if (restart) begin
      tick_cnt <= '0;
      samp_idx <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_idx <= (samp_idx == IDX_LAST) ? '0 : samp_idx + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Capture the first two of the three centre samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else if (tick) begin
      if (samp_idx == IDX_V0) v0 <= rx_s;
      if (samp_idx == IDX_V1) v1 <= rx_s;
    end
  end

  // Edge, tick and vote decision; third sample is the live one.
  always_comb begin
    rx_s      = sync[1];
    fall_edge = armed & rx_prev & ~rx_s;
    tick      = (tick_cnt == TICK_LAST);
    bit_valid = tick && (samp_idx == IDX_V2);
    bit_value = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: frame FSM, data shift register, parity check and a single
// holding register drained over valid/ready with overrun reporting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 250000,
  parameter int N_BITS     = 8,
  parameter int N_SAMPLES  = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [N_BITS-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int      DIVISOR   = CLOCK_RATE / (BAUD_RATE * N_SAMPLES);
  localparam bit      CFG_OK    = params_ok(CLOCK_RATE, BAUD_RATE, N_BITS,
                                            N_SAMPLES, PARITY, STOP_BITS);
  localparam parity_t PAR_MODE  = parity_t'(2'(PARITY));
  localparam logic    PAR_ODD_B = (PAR_MODE == PAR_ODD);
  localparam logic [3:0] LAST_DATA = 4'(N_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("uart_rx_core: unsupported parameter set (DIVISOR must be >= 2)");
  end

  state_t            state, state_nxt;
  logic              rx_s, fall_edge, bit_valid, bit_value;
  logic              restart, complete, accept;
  logic [3:0]        bit_cnt;
  logic [N_BITS-1:0] shreg;
  logic              par_acc, par_err, stop_err;

  uart_rx_sampler #(
    .DIVISOR  (DIVISOR),
    .N_SAMPLES(N_SAMPLES)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .restart  (restart),
    .rx_s     (rx_s),
    .fall_edge(fall_edge),
    .bit_valid(bit_valid),
    .bit_value(bit_value)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; every bit-level move happens on a vote decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall_edge) state_nxt = START;
      START: if (bit_valid) state_nxt = bit_value ? IDLE : DATA;
      DATA:
        if (bit_valid && bit_cnt == LAST_DATA)
          state_nxt = (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
      uart_pkg::PARITY: if (bit_valid) state_nxt = STOP;
      STOP:
        if (bit_valid && bit_cnt == LAST_STOP)
          state_nxt = bit_value ? IDLE : BREAK;
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM-derived strobes.
  always_comb begin
    busy     = (state != IDLE);
    restart  = (state == IDLE) && fall_edge;
    complete = (state == STOP) && bit_valid && (bit_cnt == LAST_STOP);
    accept   = valid && ready;
  end

  // Frame datapath: bit counter, LSB-first shift, parity and stop tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        START: begin
          bit_cnt  <= '0;
          par_acc  <= 1'b0;
          par_err  <= 1'b0;
          stop_err <= 1'b0;
        end
        DATA: begin
          shreg   <= {bit_value, shreg[N_BITS-1:1]};
          par_acc <= par_acc ^ bit_value;
          bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 4'd1;
        end
        uart_pkg::PARITY: par_err <= par_acc ^ bit_value ^ PAR_ODD_B;
        STOP: begin
          stop_err <= stop_err | ~bit_value;
          bit_cnt  <= bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Holding register and handshake; a completion against a stalled
  // consumer is dropped and flagged instead of overwriting the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= complete && valid && !ready;
      if (complete && (!valid || accept)) begin
        data       <= shreg;
        frame_err  <= stop_err | ~bit_value;
        parity_err <= (PAR_MODE != PAR_NONE) & par_err;
        valid      <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance,
// checked against a queue of expected words built from the frame contents.
module tb_uart_rx_core;

  localparam int BIT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1;
  logic [7:0] data0, data1;
  logic valid0, frame_err0, parity_err0, overrun0, busy0;
  logic valid1, frame_err1, parity_err1, overrun1, busy1;

  always #5 clk = ~clk;

  uart_rx_core u_dut (
    .clk(clk), .rst(rst), .rx(rx0), .data(data0), .valid(valid0), .ready(ready0),
    .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_core #(.PARITY(1)) u_par (
    .clk(clk), .rst(rst), .rx(rx1), .data(data1), .valid(valid1), .ready(ready1),
    .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0;
  int acc0 = 0, acc1 = 0, ovr0 = 0, ovr1 = 0, exp_ovr0 = 0;
  logic [7:0] last_d0, last_d1;
  logic last_fe0, last_pe0, last_fe1, last_pe1;
  logic hold0 = 1'b0, hold1 = 1'b0, ovp0 = 1'b0, ovp1 = 1'b0;
  logic [9:0] hw0, hw1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected word from what was put on the line: stop 0 -> framing error;
  // even parity wants an even count of ones over data+parity, odd wants odd.
  function automatic exp_t model_word(input logic [7:0] d, input bit has_par,
                                      input bit odd, input bit pbit, input bit stop);
    exp_t e;
    e.d  = d;
    e.fe = !stop;
    e.pe = has_par ? ((^d ^ pbit) != odd) : 1'b0;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
    idle(BIT);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stop);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, pbit);
    drive_bit(which, stop);
  endtask

  // Per-cycle compare: accepted words against the model queue, held words
  // must stay frozen, overrun pulses counted and must last one cycle.
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0; hold1 = 1'b0; ovp0 = 1'b0; ovp1 = 1'b0;
    end else begin
      if (hold0) chk("hold_word0", 32'({valid0, frame_err0, parity_err0, data0}), 32'({1'b1, hw0}));
      if (valid0 && ready0) begin
        acc0++;
        last_d0 = data0; last_fe0 = frame_err0; last_pe0 = parity_err0;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word0: got %0h expected none", data0);
        end else begin
          e0 = q0.pop_front();
          chk("word0", 32'({frame_err0, parity_err0, data0}), 32'({e0.fe, e0.pe, e0.d}));
        end
      end
      hold0 = valid0 && !ready0;
      hw0   = {frame_err0, parity_err0, data0};
      if (overrun0) begin ovr0++; chk("overrun_width0", 32'(ovp0), 0); end
      ovp0 = overrun0;

      if (hold1) chk("hold_word1", 32'({valid1, frame_err1, parity_err1, data1}), 32'({1'b1, hw1}));
      if (valid1 && ready1) begin
        acc1++;
        last_d1 = data1; last_fe1 = frame_err1; last_pe1 = parity_err1;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word1: got %0h expected none", data1);
        end else begin
          e1 = q1.pop_front();
          chk("word1", 32'({frame_err1, parity_err1, data1}), 32'({e1.fe, e1.pe, e1.d}));
        end
      end
      hold1 = valid1 && !ready1;
      hw1   = {frame_err1, parity_err1, data1};
      if (overrun1) begin ovr1++; chk("overrun_width1", 32'(ovp1), 0); end
      ovp1 = overrun1;
    end
  end

  int a;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    chk("reset_outputs0", 32'({data0, valid0, frame_err0, parity_err0, overrun0, busy0}), 0);
    chk("reset_outputs1", 32'({data1, valid1, frame_err1, parity_err1, overrun1, busy1}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(BIT);

    // Plain 8N1 word
    q0.push_back(model_word(8'hA5, 0, 0, 0, 1));
    send_frame(0, 8'hA5, 0, 0, 1);
    idle(BIT);
    chk("a5_count", 32'(acc0), 1);
    chk("a5_data", 32'(last_d0), 'hA5);
    chk("a5_flags", 32'({last_fe0, last_pe0}), 0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong, 1 is right
    q1.push_back(model_word(8'h07, 1, 0, 0, 1));
    send_frame(1, 8'h07, 1, 1'b0, 1);
    idle(BIT);
    chk("par_bad_data", 32'(last_d1), 'h07);
    chk("par_bad_err", 32'(last_pe1), 1);
    q1.push_back(model_word(8'h07, 1, 0, 1, 1));
    send_frame(1, 8'h07, 1, 1'b1, 1);
    idle(BIT);
    chk("par_good_err", 32'(last_pe1), 0);
    chk("par_count", 32'(acc1), 2);

    // 100-clk low glitch is rejected by the start-bit vote
    a = acc0;
    rx0 = 1'b0;
    idle(20);
    @(negedge clk);
    chk("glitch_busy", 32'(busy0), 1);
    idle(80);
    rx0 = 1'b1;
    idle(BIT);
    chk("glitch_idle", 32'(busy0), 0);
    chk("glitch_no_word", 32'(acc0), 32'(a));

    // Stop bit 0 followed by a held-low line: framing error, busy until high
    q0.push_back(model_word(8'h3C, 0, 0, 0, 0));
    send_frame(0, 8'h3C, 0, 0, 0);
    idle(2000);
    chk("break_busy", 32'(busy0), 1);
    chk("break_data", 32'(last_d0), 'h3C);
    chk("break_fe", 32'(last_fe0), 1);
    rx0 = 1'b1;
    idle(10);
    chk("break_release", 32'(busy0), 0);
    idle(BIT);
    q0.push_back(model_word(8'h55, 0, 0, 0, 1));
    send_frame(0, 8'h55, 0, 0, 1);
    idle(BIT);
    chk("after_break_data", 32'(last_d0), 'h55);
    chk("after_break_flags", 32'({last_fe0, last_pe0}), 0);

    // Stalled consumer: second word dropped with one overrun pulse
    ready0 = 1'b0;
    q0.push_back(model_word(8'h11, 0, 0, 0, 1));
    send_frame(0, 8'h11, 0, 0, 1);
    exp_ovr0++;
    send_frame(0, 8'h22, 0, 0, 1);
    idle(BIT);
    chk("ovr_valid", 32'(valid0), 1);
    chk("ovr_data", 32'(data0), 'h11);
    chk("ovr_count", 32'(ovr0), 1);
    ready0 = 1'b1;
    idle(3);
    chk("ovr_drained", 32'(valid0), 0);
    chk("ovr_last", 32'(last_d0), 'h11);

    // Reset in data bit 4 with a word held: everything clears at once
    ready0 = 1'b0;
    q0.push_back(model_word(8'h5A, 0, 0, 0, 1));
    send_frame(0, 8'h5A, 0, 0, 1);
    idle(BIT);
    chk("pre_rst_valid", 32'(valid0), 1);
    rx0 = 1'b0;
    idle(5 * BIT + BIT / 2);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    chk("rst_outputs", 32'({data0, valid0, frame_err0, parity_err0, overrun0, busy0}), 0);
    idle(5);
    rst = 1'b0;
    idle(BIT);
    chk("rst_low_line_ignored", 32'(busy0), 0);
    rx0 = 1'b1;
    idle(2 * BIT);
    ready0 = 1'b1;
    a = acc0;
    q0.push_back(model_word(8'h96, 0, 0, 0, 1));
    send_frame(0, 8'h96, 0, 0, 1);
    idle(BIT);
    chk("post_rst_count", 32'(acc0), 32'(a + 1));
    chk("post_rst_data", 32'(last_d0), 'h96);

    // Everything expected arrived, and only the planned overrun occurred
    chk("pending0", 32'(q0.size()), 0);
    chk("pending1", 32'(q1.size()), 0);
    chk("overruns0", 32'(ovr0), 32'(exp_ovr0));
    chk("overruns1", 32'(ovr1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
